// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared definitions for the keypad scan controller.
//   scan_state_t : controller FSM states
//   COL_*        : one-hot column strobe values (bit2=a, bit1=b, bit0=c)
//   ROW_*        : row bit indices into the row bus (bit3=d .. bit0=g)
//   ROW_*_BIT    : one-hot row patterns derived from the indices
//   next_col()   : column rotation a -> b -> c -> a
package keypad_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    RELEASE  = 2'd2
  } scan_state_t;

  localparam logic [2:0] COL_A = 3'b100;
  localparam logic [2:0] COL_B = 3'b010;
  localparam logic [2:0] COL_C = 3'b001;

  localparam int ROW_D = 3;
  localparam int ROW_E = 2;
  localparam int ROW_F = 1;
  localparam int ROW_G = 0;

  localparam logic [3:0] ROW_D_BIT = 4'b0001 << ROW_D;
  localparam logic [3:0] ROW_E_BIT = 4'b0001 << ROW_E;
  localparam logic [3:0] ROW_F_BIT = 4'b0001 << ROW_F;
  localparam logic [3:0] ROW_G_BIT = 4'b0001 << ROW_G;

  function automatic logic [2:0] next_col(input logic [2:0] col);
    case (col)
      COL_A:   next_col = COL_B;
      COL_B:   next_col = COL_C;
      default: next_col = COL_A;
    endcase
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_keypad.sv
// Combinational phone keypad encoder.
//   a, b, c    : column lines (one-hot when a single column is strobed)
//   d, e, f, g : row lines
//   valid      : exactly one legal key position is active
//   number     : decoded digit 0-9 (0 when not valid)
// The * (a/g) and # (c/g) positions and every multi-line pattern decode
// as not valid.
module keypad
  import keypad_scan_ctrl_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  output logic       valid,
  output logic [3:0] number
);

  logic [6:0] key;

  assign key = {a, b, c, d, e, f, g};

  always_comb begin
    valid  = 1'b1;
    number = 4'd0;
    case (key)
      {COL_A, ROW_D_BIT}: number = 4'd1;
      {COL_B, ROW_D_BIT}: number = 4'd2;
      {COL_C, ROW_D_BIT}: number = 4'd3;
      {COL_A, ROW_E_BIT}: number = 4'd4;
      {COL_B, ROW_E_BIT}: number = 4'd5;
      {COL_C, ROW_E_BIT}: number = 4'd6;
      {COL_A, ROW_F_BIT}: number = 4'd7;
      {COL_B, ROW_F_BIT}: number = 4'd8;
      {COL_C, ROW_F_BIT}: number = 4'd9;
      {COL_B, ROW_G_BIT}: number = 4'd0;
      default:            valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad scan controller: strobes the 3 columns in turn, samples the
// synchronized rows, debounces a single legal press, waits for release,
// and hands one digit per press to the consumer through a one-entry
// valid/ready holding register.
//   clk, reset : clock, async active-high reset
//   cols       : one-hot column strobe (bit2=a, bit1=b, bit0=c)
//   rows       : raw asynchronous row lines (bit3=d .. bit0=g)
//   key_code   : digit held in the holding register
//   key_valid  : holding register full
//   key_ready  : consumer accept
//   overrun    : sticky, a confirmed press was dropped (register full)
//
// state    | meaning
// SCAN     | drive each column SCAN_DIV cycles, look for a key on the last one
// DEBOUNCE | cols frozen, need DEBOUNCE_CYC consecutive samples equal to candidate
// RELEASE  | cols frozen, need DEBOUNCE_CYC consecutive all-zero samples
module keypad_scan_ctrl
  import keypad_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CYC = 8
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] cols,
  input  logic [3:0] rows,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overrun
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);

  logic [3:0]    rows_m, rows_s;
  scan_state_t   state, state_nxt;
  logic [2:0]    cols_nxt;
  logic [SW-1:0] scan_cnt, scan_cnt_nxt;
  logic [DW-1:0] deb_cnt, deb_cnt_nxt;
  logic [3:0]    cand_rows, cand_rows_nxt;
  logic [3:0]    enc_rows;
  logic          enc_valid;
  logic [3:0]    enc_number;
  logic          key_seen;
  logic          confirm;

  // While scanning the encoder judges the live sample; afterwards it
  // decodes the latched candidate so the confirmed digit is stable.
  assign enc_rows = (state == SCAN) ? rows_s : cand_rows;

  keypad u_keypad (
    .a      (cols[2]),
    .b      (cols[1]),
    .c      (cols[0]),
    .d      (enc_rows[3]),
    .e      (enc_rows[2]),
    .f      (enc_rows[1]),
    .g      (enc_rows[0]),
    .valid  (enc_valid),
    .number (enc_number)
  );

  assign key_seen = $onehot(rows_s) && enc_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_m <= '0;
      rows_s <= '0;
    end else begin
      rows_m <= rows;
      rows_s <= rows_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      cols      <= COL_A;
      scan_cnt  <= '0;
      deb_cnt   <= '0;
      cand_rows <= '0;
    end else begin
      state     <= state_nxt;
      cols      <= cols_nxt;
      scan_cnt  <= scan_cnt_nxt;
      deb_cnt   <= deb_cnt_nxt;
      cand_rows <= cand_rows_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cols_nxt      = cols;
    scan_cnt_nxt  = scan_cnt;
    deb_cnt_nxt   = deb_cnt;
    cand_rows_nxt = cand_rows;
    confirm       = 1'b0;
    case (state)
      SCAN: begin
        if (scan_cnt == SCAN_LAST) begin
          scan_cnt_nxt = '0;
          if (key_seen) begin
            cand_rows_nxt = rows_s;
            deb_cnt_nxt   = '0;
            state_nxt     = DEBOUNCE;
          end else begin
            cols_nxt = next_col(cols);
          end
        end else begin
          scan_cnt_nxt = scan_cnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (rows_s != cand_rows) begin
          state_nxt    = SCAN;
          cols_nxt     = next_col(cols);
          scan_cnt_nxt = '0;
          deb_cnt_nxt  = '0;
        end else if (deb_cnt == DEB_LAST) begin
          confirm     = 1'b1;
          state_nxt   = RELEASE;
          deb_cnt_nxt = '0;
        end else begin
          deb_cnt_nxt = deb_cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (rows_s != 4'b0000) begin
          deb_cnt_nxt = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt    = SCAN;
          cols_nxt     = COL_A;
          scan_cnt_nxt = '0;
          deb_cnt_nxt  = '0;
        end else begin
          deb_cnt_nxt = deb_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt    = SCAN;
        cols_nxt     = COL_A;
        scan_cnt_nxt = '0;
        deb_cnt_nxt  = '0;
      end
    endcase
  end

  // A confirm may load in the same cycle the consumer empties the register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (confirm && (!key_valid || key_ready)) begin
      key_code  <= enc_number;
      key_valid <= 1'b1;
    end else begin
      if (confirm) begin
        overrun <= 1'b1;
      end
      if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl (SCAN_DIV=4, DEBOUNCE_CYC=8).
// The keypad is modelled as a switch matrix: the pressed key drives its
// row pattern only while its column is strobed.
module tb_keypad_scan_ctrl;
  import keypad_scan_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] cols;
  logic [3:0] rows;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       overrun;

  logic [2:0] key_col;
  logic [3:0] key_rows;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [2:0] col;
    logic [3:0] rws;
    bit         legal;
    int         code;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  assign rows = ((cols & key_col) != 3'b000) ? key_rows : 4'b0000;

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CYC(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .cols      (cols),
    .rows      (rows),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .overrun   (overrun)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_cycles(input int n, output int vcnt);
    vcnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (key_valid) vcnt++;
    end
  endtask

  task automatic wait_valid(input int max, output int lat);
    lat = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (key_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_overrun(input int max, output int lat);
    lat = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (overrun) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_cols(input logic [2:0] c, input int max, output int ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (cols == c) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic press(input logic [2:0] c, input logic [3:0] r);
    key_col  = c;
    key_rows = r;
  endtask

  task automatic unpress();
    key_col  = 3'b000;
    key_rows = 4'b0000;
  endtask

  task automatic accept_pulse();
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, vcnt, ok, code, extra, good;

    vecs[0]  = '{COL_A, ROW_D_BIT, 1'b1, 1};
    vecs[1]  = '{COL_B, ROW_D_BIT, 1'b1, 2};
    vecs[2]  = '{COL_C, ROW_D_BIT, 1'b1, 3};
    vecs[3]  = '{COL_A, ROW_E_BIT, 1'b1, 4};
    vecs[4]  = '{COL_C, ROW_E_BIT, 1'b1, 6};
    vecs[5]  = '{COL_A, ROW_F_BIT, 1'b1, 7};
    vecs[6]  = '{COL_B, ROW_F_BIT, 1'b1, 8};
    vecs[7]  = '{COL_C, ROW_F_BIT, 1'b1, 9};
    vecs[8]  = '{COL_B, ROW_G_BIT, 1'b1, 0};
    vecs[9]  = '{COL_A, ROW_G_BIT, 1'b0, 0};
    vecs[10] = '{COL_C, ROW_G_BIT, 1'b0, 0};
    vecs[11] = '{COL_B, 4'b1100,   1'b0, 0};
    vecs[12] = '{COL_A, 4'b1010,   1'b0, 0};

    unpress();
    key_ready = 1'b0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_cols", int'(cols), int'(COL_A));
    check("reset_valid", int'(key_valid), 0);
    check("reset_code", int'(key_code), 0);
    check("reset_overrun", int'(overrun), 0);
    reset = 1'b0;

    // clean press b/e with consumer always ready
    key_ready = 1'b1;
    press(COL_B, ROW_E_BIT);
    vcnt = 0; lat = -1; code = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (key_valid) begin
        vcnt++;
        if (lat < 0) begin
          lat  = i;
          code = int'(key_code);
        end
      end
    end
    unpress();
    run_cycles(30, extra);
    check("clean_pulses", vcnt, 1);
    check("clean_code", code, 5);
    check("clean_latency_le_24", int'(lat >= 1 && lat <= 24), 1);
    check("clean_no_repeat", extra, 0);
    key_ready = 1'b0;

    // every key position plus illegal patterns
    for (int v = 0; v < 13; v++) begin
      press(vecs[v].col, vecs[v].rws);
      if (vecs[v].legal) begin
        wait_valid(40, lat);
        check($sformatf("vec%0d_latency_le_24", v), int'(lat >= 1 && lat <= 24), 1);
        check($sformatf("vec%0d_code", v), int'(key_code), vecs[v].code);
        good = 0;
        repeat (10) begin
          @(negedge clk);
          if (key_valid && int'(key_code) == vecs[v].code) good++;
        end
        check($sformatf("vec%0d_held", v), good, 10);
        unpress();
        accept_pulse();
        check($sformatf("vec%0d_cleared", v), int'(key_valid), 0);
        run_cycles(20, vcnt);
        check($sformatf("vec%0d_no_repeat", v), vcnt, 0);
      end else begin
        run_cycles(50, vcnt);
        check($sformatf("vec%0d_rejected", v), vcnt, 0);
        unpress();
        run_cycles(20, vcnt);
      end
    end

    // bouncing contact on c/f, then steady
    vcnt = 0;
    key_col = COL_C;
    for (int t = 0; t < 60; t++) begin
      key_rows = (((t / 3) % 2) == 1) ? 4'b0000 : ROW_F_BIT;
      @(negedge clk);
      if (key_valid) vcnt++;
    end
    check("bounce_no_valid", vcnt, 0);
    key_rows = ROW_F_BIT;
    wait_valid(40, lat);
    check("bounce_settled_valid", int'(lat > 0), 1);
    check("bounce_code", int'(key_code), 9);
    unpress();
    accept_pulse();
    run_cycles(20, vcnt);

    // backpressure and overrun
    press(COL_A, ROW_D_BIT);
    wait_valid(40, lat);
    check("bp_first_valid", int'(lat > 0), 1);
    unpress();
    run_cycles(20, vcnt);
    check("bp_held_while_idle", vcnt, 20);
    press(COL_B, ROW_G_BIT);
    wait_overrun(40, lat);
    check("bp_overrun_set", int'(overrun), 1);
    check("bp_valid_kept", int'(key_valid), 1);
    check("bp_code_kept", int'(key_code), 1);
    unpress();
    run_cycles(20, vcnt);
    check("bp_code_after_idle", int'(key_code), 1);
    accept_pulse();
    check("bp_valid_cleared", int'(key_valid), 0);
    check("bp_overrun_sticky", int'(overrun), 1);

    // reset in the middle of debounce, with a digit pending
    press(COL_B, ROW_E_BIT);
    wait_valid(40, lat);
    unpress();
    run_cycles(20, vcnt);
    check("rst_pending_valid", int'(key_valid), 1);
    wait_cols(COL_A, 20, ok);
    check("rst_reach_col_a", ok, 1);
    press(COL_B, ROW_E_BIT);
    wait_cols(COL_B, 20, ok);
    check("rst_reach_col_b", ok, 1);
    repeat (6) @(negedge clk);
    check("rst_cols_frozen", int'(cols), int'(COL_B));
    reset = 1'b1;
    #1;
    check("rst_async_cols", int'(cols), int'(COL_A));
    check("rst_async_valid", int'(key_valid), 0);
    check("rst_async_overrun", int'(overrun), 0);
    unpress();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_resume_col_a", int'(cols), int'(COL_A));
    @(negedge clk);
    check("rst_rotate_col_b", int'(cols), int'(COL_B));

    // accept and load on the same edge
    press(COL_A, ROW_F_BIT);
    wait_valid(40, lat);
    check("same_first_code", int'(key_code), 7);
    unpress();
    run_cycles(20, vcnt);
    wait_cols(COL_A, 20, ok);
    press(COL_C, ROW_D_BIT);
    wait_cols(COL_C, 20, ok);
    check("same_reach_col_c", ok, 1);
    repeat (11) @(negedge clk);
    check("same_pre_code", int'(key_code), 7);
    accept_pulse();
    check("same_valid_kept", int'(key_valid), 1);
    check("same_code_loaded", int'(key_code), 3);
    check("same_no_overrun", int'(overrun), 0);
    @(negedge clk);
    check("same_valid_holds", int'(key_valid), 1);
    unpress();
    run_cycles(20, vcnt);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Sequencer for the 3-column x 4-row phone keypad: strobes one column at a time, samples the row lines, debounces a single key press and waits for its release.
- Reuses the existing combinational keypad encoder to turn {column, row} into a digit.
- Delivers one 4-bit digit per physical press to the consumer over a valid/ready handshake with a one-entry holding register.
- Sits between the keypad pins and the lab's input consumer, e.g. a number accumulator or display.

Parameters:
- SCAN_DIV, 4: cycles each column is driven during SCAN. Must be >= 3 (covers the 2-flop synchronizer).
- DEBOUNCE_CYC, 8: consecutive identical samples required to accept a press or a release. Must be >= 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- cols  out  3  one-hot column strobe; bit2=a, bit1=b, bit0=c.
- rows  in  4  raw row lines; bit3=d, bit2=e, bit1=f, bit0=g. Asynchronous, bouncy.
- key_code  out  4  decoded digit 0-9, held stable while key_valid=1.
- key_valid  out  1  holding register full.
- key_ready  in  1  consumer accepts when key_valid&key_ready at a clk edge.
- overrun  out  1  sticky: a confirmed press was dropped because the holding register was full.

Behaviour:
- Reset (async, active-high): cols=3'b100, key_code=0, key_valid=0, overrun=0, FSM=SCAN, all counters=0, synchronizer flops=0.
- Synchronizer: rows pass through 2 flops to give rows_s. All decisions use rows_s only.
- Key legality: "key seen" means rows_s has exactly one bit set AND the encoder valid=1 for {cols, rows_s}.
  - Multi-row presses and the illegal a/g and c/g positions are treated as "no key".
- FSM states:
  - SCAN: drive the current column for SCAN_DIV cycles. In the last dwell cycle, if a key is seen, latch {cols, rows_s} as the candidate and go to DEBOUNCE with cols frozen. Otherwise rotate a->b->c->a.
  - DEBOUNCE: each cycle compare rows_s with the candidate rows. After DEBOUNCE_CYC consecutive matches, confirm the press and go to RELEASE. Any mismatch: return to SCAN and rotate to the next column.
  - RELEASE: cols frozen. Wait for rows_s==0 for DEBOUNCE_CYC consecutive cycles; any nonzero sample restarts the count. Then go to SCAN with cols=a.
- On confirm:
  - If holding register empty, or being emptied in the same cycle (key_valid&key_ready): load the encoder number and set key_valid=1 next cycle.
  - Else: drop the press, set overrun=1. The key_code in the register is unchanged.
- Handshake:
  - key_valid clears on the cycle after key_valid&key_ready unless a new confirm loads in the same cycle.
  - key_code must not change while key_valid=1 and key_ready=0.
  - key_ready while key_valid=0 is ignored.
- Counters are sized to $clog2 of the parameter and saturate at their terminal value. No wrap-around in DEBOUNCE or RELEASE.
- Holding a key produces exactly one digit. Repeat requires release then a re-press.
- overrun clears only on reset.
- Reset asserted mid-debounce or mid-release: immediate return to the reset state. A pending key_valid is lost.
- Worst-case latency from a stable press to key_valid: 3*SCAN_DIV + DEBOUNCE_CYC + 4 cycles. This is 24 cycles at defaults.

Decomposition:
- Shared package:
  - FSM state enum (SCAN, DEBOUNCE, RELEASE).
  - Column one-hot constants COL_A=3'b100, COL_B=3'b010, COL_C=3'b001.
  - Row index constants.
- Sub-module: instantiate the existing combinational encoder `keypad` (ports valid, number, a..g) once, driven from the cols/candidate row signals. Its valid output is the legality check.
- Synchronizer and counters stay inline.

Test Plan:
- Reset mid-run: assert reset during DEBOUNCE -> same cycle cols=3'b100, key_valid=0, overrun=0. After release, scanning resumes at column a.
- Clean press b/e (cols bit1, rows=4'b0100) held 40 cycles, key_ready=1 -> exactly one key_valid pulse with key_code=5, within 24 cycles of press. No second pulse after release and 20 idle cycles.
- Bounce: rows toggles 4'b0010 / 4'b0000 every 3 cycles, then steady 4'b0010 on column c -> no key_valid during toggling. key_code=9 after stabilizing.
- Illegal and multi-key: press a/g (rows=4'b0001 while col a) for 50 cycles -> key_valid stays 0. Press rows=4'b1100 on column b -> key_valid stays 0.
- Backpressure and overrun: key_ready=0; press 1 (a/d), release, press 0 (b/g) -> key_valid=1, key_code=1 held, overrun=1. Then key_ready=1 for one cycle -> key_valid=0 next cycle, overrun stays 1.
- Accept-and-load same cycle: time a confirm of key 3 (c/d) on the same edge as key_valid&key_ready -> key_valid stays 1, key_code=3, overrun=0.
